// File: rtl/block_to_raster_reorder.sv
// block_to_raster_reorder
//   Copies one sample plane from 8x8-block order (64 words per block, blocks
//   left-to-right then top-to-bottom) into raster order, one sample per cycle.
//   The SRAM read has a fixed one-cycle latency, so each write is the read
//   issued on the previous cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      single-cycle start request, accepted only when idle
//   done       single-cycle completion pulse
//   busy       high while reads or writes are outstanding
//   raddr      SRAM read address
//   rdata      SRAM read data, valid one cycle after raddr
//   waddr      SRAM write address
//   wdata      SRAM write data
//   wr_enable  SRAM write strobe
//
// Optional feature (macro REORDER_CLIP_EN)
//   When defined, rdata is treated as signed and saturated to 0..255 before it
//   is written. When undefined, rdata is written unmodified.

module block_to_raster_reorder #(
    parameter int unsigned ADDR_SRC = 0,
    parameter int unsigned ADDR_DST = 115200,
    parameter int unsigned W        = 320,
    parameter int unsigned H        = 240,
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          wr_enable
);

    localparam int unsigned BXN = W / 8;
    localparam int unsigned BYN = H / 8;
    localparam int unsigned BXW = $clog2(BXN + 1);
    localparam int unsigned BYW = $clog2(BYN + 1);

    localparam logic [AW-1:0] SrcBase = AW'(ADDR_SRC);
    localparam logic [AW-1:0] DstBase = AW'(ADDR_DST);
    // From the end of one block row to the start of the next row in the block.
    localparam logic [AW-1:0] RowStep = AW'(W - 7);
    // From the bottom-right of a block back up to the top-left of the next one.
    localparam logic [AW-1:0] BlkBack = AW'(7 * W - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           r_state;
    logic [2:0]       r_c;
    logic [2:0]       r_r;
    logic [BXW-1:0]   r_bx;
    logic [BYW-1:0]   r_by;
    logic [AW-1:0]    r_dst;

    logic             w_c_wrap;
    logic             w_r_wrap;
    logic             w_bx_wrap;
    logic             w_last;
    logic [AW-1:0]    w_dst_next;
    logic [DW-1:0]    w_pix;

    assign w_c_wrap  = (r_c == 3'd7);
    assign w_r_wrap  = w_c_wrap && (r_r == 3'd7);
    assign w_bx_wrap = w_r_wrap && (r_bx == BXW'(BXN - 1));
    assign w_last    = w_bx_wrap && (r_by == BYW'(BYN - 1));

    // Incremental destination address. At the end of a block strip the last
    // sample of the strip is immediately followed in raster order by the first
    // sample of the next strip, hence +1.
    always_comb begin
        w_dst_next = r_dst + AW'(1);
        if (w_c_wrap) begin
            if (!w_r_wrap) begin
                w_dst_next = r_dst + RowStep;
            end else if (!w_bx_wrap) begin
                w_dst_next = r_dst - BlkBack;
            end
        end
    end

`ifdef REORDER_CLIP_EN
    always_comb begin
        w_pix = rdata;
        if (rdata[DW-1]) begin
            w_pix = '0;
        end else if (rdata > DW'(255)) begin
            w_pix = DW'(255);
        end
    end
`else
    assign w_pix = rdata;
`endif

    // Gated so wdata reads 0 whenever no write is in flight (including reset).
    assign wdata = wr_enable ? w_pix : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_c       <= '0;
            r_r       <= '0;
            r_bx      <= '0;
            r_by      <= '0;
            r_dst     <= '0;
            raddr     <= '0;
            waddr     <= '0;
            wr_enable <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state <= StRun;
                        busy    <= 1'b1;
                        r_c     <= '0;
                        r_r     <= '0;
                        r_bx    <= '0;
                        r_by    <= '0;
                        r_dst   <= DstBase;
                        raddr   <= SrcBase;
                    end
                end
                StRun: begin
                    // Read is on the bus this cycle; its write lands next cycle.
                    waddr     <= r_dst;
                    wr_enable <= 1'b1;
                    r_dst     <= w_dst_next;
                    r_c       <= r_c + 3'd1;
                    if (w_c_wrap) begin
                        r_r <= r_r + 3'd1;
                    end
                    if (w_r_wrap) begin
                        r_bx <= w_bx_wrap ? '0 : r_bx + 1'b1;
                    end
                    if (w_bx_wrap) begin
                        r_by <= r_by + 1'b1;
                    end
                    if (w_last) begin
                        r_state <= StDrain;
                    end else begin
                        raddr <= raddr + AW'(1);
                    end
                end
                StDrain: begin
                    wr_enable <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    r_state   <= StDone;
                end
                StDone: begin
                    done    <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_block_to_raster_reorder.sv
module tb_block_to_raster_reorder;

    logic        clk;
    logic        reset;

    // Small 16x16 instance
    logic        start;
    logic        done;
    logic        busy;
    logic [17:0] raddr;
    logic [15:0] rdata;
    logic [17:0] waddr;
    logic [15:0] wdata;
    logic        wr_enable;

    // Default-size instance
    logic        start_big;
    logic        done_big;
    logic        busy_big;
    logic [17:0] raddr_big;
    logic [15:0] rdata_big;
    logic [17:0] waddr_big;
    logic [15:0] wdata_big;
    logic        wr_enable_big;

    logic [15:0] mem [256];

    int checks;
    int errors;

    // Results of the last small run
    logic [17:0] wa [256];
    logic [15:0] wd [256];
    int nw;
    int done_n;
    int done_cnt;
    int rd_bad;
    int wr_first;
    int wr_last;

    block_to_raster_reorder #(
        .ADDR_SRC (0),
        .ADDR_DST (1000),
        .W        (16),
        .H        (16),
        .DW       (16),
        .AW       (18)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .raddr     (raddr),
        .rdata     (rdata),
        .waddr     (waddr),
        .wdata     (wdata),
        .wr_enable (wr_enable)
    );

    block_to_raster_reorder u_big (
        .clk       (clk),
        .reset     (reset),
        .start     (start_big),
        .done      (done_big),
        .busy      (busy_big),
        .raddr     (raddr_big),
        .rdata     (rdata_big),
        .waddr     (waddr_big),
        .wdata     (wdata_big),
        .wr_enable (wr_enable_big)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models with one-cycle read latency
    always @(posedge clk) begin
        rdata     <= mem[raddr[7:0]];
        rdata_big <= raddr_big[15:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start the small DUT and watch 400 cycles; n counts cycles after the start edge.
    task automatic run_small(input int restart_at);
        int n;
        nw = 0; done_n = 0; done_cnt = 0; rd_bad = 0; wr_first = 0; wr_last = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n <= 400) begin
            if (n <= 256 && raddr !== 18'(n - 1)) rd_bad++;
            if (wr_enable) begin
                if (nw < 256) begin
                    wa[nw] = waddr;
                    wd[nw] = wdata;
                end
                if (nw == 0) wr_first = n;
                wr_last = n;
                nw++;
            end
            if (done) begin
                done_cnt++;
                if (done_n == 0) done_n = n;
            end
            start = (n == restart_at);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    // Independent raster address model for the 16x16 plane at base 1000.
    function automatic int exp_dst(input int s);
        int c, r, bx, by;
        c  = s % 8;
        r  = (s / 8) % 8;
        bx = (s / 64) % 2;
        by = s / 128;
        return 1000 + (by * 8 + r) * 16 + bx * 8 + c;
    endfunction

    task automatic check_full_run(input string tag);
        int abad, dbad;
        abad = 0; dbad = 0;
        for (int s = 0; s < 256; s++) begin
            if (wa[s] !== 18'(exp_dst(s))) abad++;
            if (wd[s] !== 16'(s)) dbad++;
        end
        check({tag, "_nwrites"}, nw, 256);
        check({tag, "_addr_errs"}, abad, 0);
        check({tag, "_data_errs"}, dbad, 0);
        check({tag, "_done_at"}, done_n, 258);
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        int n;
        int big_nw;
        int big_done;
        logic [17:0] big_last;

        checks = 0;
        errors = 0;
        start = 1'b0;
        start_big = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);

        #3;
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_wr", wr_enable, 0);
        check("rst_raddr", raddr, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);

        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic run
        run_small(0);
        check_full_run("run1");
        check("s0_waddr", wa[0], 1000);
        check("s9_waddr", wa[9], 1017);
        check("s64_waddr", wa[64], 1008);
        check("s128_waddr", wa[128], 1128);
        check("s255_waddr", wa[255], 1255);
        check("wr_first", wr_first, 2);
        check("wr_last", wr_last, 257);
        check("raddr_seq_errs", rd_bad, 0);

        // Start pulse during the run must be ignored
        run_small(20);
        check_full_run("restart");

        // Asynchronous reset in the middle of the transfer
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nw = 0;
        n = 0;
        while (nw < 100 && n < 400) begin
            @(negedge clk);
            if (wr_enable) nw++;
            n++;
        end
        check("reach_write100", nw, 100);
        #2 reset = 1'b0;
        #1;
        check("arst_wr", wr_enable, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_enable || done || busy) n++;
        end
        check("post_rst_quiet", n, 0);
        run_small(0);
        check_full_run("after_rst");

        // Saturation behaviour on out-of-range samples
        mem[0] = 16'hFFF0;
        mem[1] = 16'd300;
        mem[2] = 16'd128;
        run_small(0);
`ifdef REORDER_CLIP_EN
        check("clip_neg", wd[0], 0);
        check("clip_hi", wd[1], 255);
`else
        check("pass_neg", wd[0], 16'hFFF0);
        check("pass_hi", wd[1], 300);
`endif
        check("pass_mid", wd[2], 128);
        check("clip_run_writes", nw, 256);

        // Default 320x240 instance
        @(negedge clk);
        start_big = 1'b1;
        @(negedge clk);
        start_big = 1'b0;
        n = 1;
        big_nw = 0;
        big_done = 0;
        big_last = '0;
        while (big_done == 0 && n <= 77000) begin
            if (wr_enable_big) begin
                big_last = waddr_big;
                big_nw++;
            end
            if (done_big) big_done = n;
            @(negedge clk);
            n++;
        end
        check("big_done_at", big_done, 76802);
        check("big_nwrites", big_nw, 76800);
        check("big_last_waddr", big_last, 115200 + 76799);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
